// File: rtl/r4_pkg.sv
// Shared opcode, ALU and state definitions for the R4 multi-cycle control path.
package r4_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;

   localparam logic [1:0] PRE_ADD   = 2'b00;
   localparam logic [1:0] PRE_SUB   = 2'b01;
   localparam logic [1:0] PRE_FUNCT = 2'b10;
   localparam logic [1:0] PRE_IMM   = 2'b11;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'b00,
      CAUSE_ILLEGAL = 2'b01,
      CAUSE_TIMEOUT = 2'b10
   } trap_cause_t;

   typedef enum logic [2:0] {I_LW, I_SW, I_ADDI, I_REG, I_BEQ, I_BNE, I_ILLEGAL} iclass_t;

   function automatic iclass_t classify(input logic [31:0] instr);
      iclass_t c;
      c = I_ILLEGAL;
      case (instr[6:0])
         OP_LOAD:   c = I_LW;
         OP_STORE:  c = I_SW;
         OP_IMM:    if (instr[14:12] == 3'b000) c = I_ADDI;
         OP_REG:    if (instr[14:12] == 3'b000 &&
                        (instr[31:25] == 7'b0000000 || instr[31:25] == 7'b0100000)) c = I_REG;
         OP_BRANCH: begin
            if (instr[14:12] == 3'b000)      c = I_BEQ;
            else if (instr[14:12] == 3'b001) c = I_BNE;
         end
         default:   c = I_ILLEGAL;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_controller.sv
// Maps the FSM's coarse ALU request plus instruction function fields onto an ALU opcode.
module alu_controller
   import r4_pkg::*;
(
   input  logic [1:0] pre_op,
   input  logic [6:0] funct7,
   input  logic [2:0] funct3,
   output logic [3:0] alu_op
);

   always_comb begin
      alu_op = ALU_ADD;
      case (pre_op)
         PRE_ADD:   alu_op = ALU_ADD;
         PRE_SUB:   alu_op = ALU_SUB;
         PRE_FUNCT: if (funct3 == 3'b000 && funct7 == 7'b0100000) alu_op = ALU_SUB;
         PRE_IMM:   alu_op = ALU_ADD;
         default:   alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the R4 core with retire counting and traps.
//  state  | meaning
//  FETCH  | read instruction at PC, load IR on mem_ready
//  DECODE | classify IR, trap on illegal encodings
//  EXEC   | drive ALU; branches resolve and retire here
//  MEM    | data access at ALU address; sw retires on mem_ready
//  WB     | register write, retire
//  TRAP   | halted until reset
module multicycle_controller
   import r4_pkg::*;
#(
   parameter int INSTRET_W  = 32,
   parameter int WAIT_LIMIT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          instr,
   input  logic                 mem_ready,
   input  logic                 alu_zero,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 mem_addr_src,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 pc_src,
   output logic                 alu_src,
   output logic [3:0]           alu_op,
   output logic                 reg_write,
   output logic                 mem_to_reg,
   output logic                 trap,
   output logic [1:0]           trap_cause,
   output logic [INSTRET_W-1:0] instret
);

   localparam int WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

   state_t               state, next_state;
   trap_cause_t          cause_q, cause_d;
   logic [WAIT_W-1:0]    wait_cnt;
   logic [INSTRET_W-1:0] instret_q;
   iclass_t              iclass;
   logic [1:0]           pre_op;
   logic [3:0]           alu_op_dec;
   logic                 mem_phase, wait_expired, uses_rs2, is_branch;

   assign iclass    = classify(instr);
   assign mem_phase = (state == FETCH) || (state == MEM);
   assign uses_rs2  = (iclass == I_REG) || (iclass == I_BEQ) || (iclass == I_BNE);
   assign is_branch = (iclass == I_BEQ) || (iclass == I_BNE);
   // Expires on the wait cycle that would bring the counter up to the limit.
   assign wait_expired = (WAIT_LIMIT != 0) && mem_phase && !mem_ready &&
                         (int'(wait_cnt) == WAIT_LIMIT - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= FETCH;
         cause_q <= CAUSE_NONE;
      end else begin
         state   <= next_state;
         cause_q <= cause_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !mem_phase || mem_ready || next_state != state) wait_cnt <= '0;
      else                                                      wait_cnt <= wait_cnt + WAIT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)           instret_q <= '0;
      else if (pc_write) instret_q <= instret_q + INSTRET_W'(1);
   end

   always_comb begin
      next_state = state;
      cause_d    = cause_q;
      case (state)
         FETCH: begin
            if (mem_ready) next_state = DECODE;
            else if (wait_expired) begin
               next_state = TRAP;
               cause_d    = CAUSE_TIMEOUT;
            end
         end
         DECODE: begin
            if (iclass == I_ILLEGAL) begin
               next_state = TRAP;
               cause_d    = CAUSE_ILLEGAL;
            end else begin
               next_state = EXEC;
            end
         end
         EXEC: begin
            case (iclass)
               I_LW, I_SW:    next_state = MEM;
               I_ADDI, I_REG: next_state = WB;
               default:       next_state = FETCH;
            endcase
         end
         MEM: begin
            if (mem_ready) next_state = (iclass == I_SW) ? FETCH : WB;
            else if (wait_expired) begin
               next_state = TRAP;
               cause_d    = CAUSE_TIMEOUT;
            end
         end
         WB:      next_state = FETCH;
         TRAP:    next_state = TRAP;
         default: next_state = FETCH;
      endcase
   end

   always_comb begin
      case (iclass)
         I_REG:        pre_op = PRE_FUNCT;
         I_BEQ, I_BNE: pre_op = PRE_SUB;
         I_ADDI:       pre_op = PRE_IMM;
         default:      pre_op = PRE_ADD;
      endcase
   end

   alu_controller u_alu_ctrl (
      .pre_op (pre_op),
      .funct7 (instr[31:25]),
      .funct3 (instr[14:12]),
      .alu_op (alu_op_dec)
   );

   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_src = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      alu_src      = 1'b0;
      alu_op       = ALU_ADD;
      reg_write    = 1'b0;
      mem_to_reg   = 1'b0;
      trap         = 1'b0;
      trap_cause   = CAUSE_NONE;
      instret      = '0;
      if (!rst) begin
         case (state)
            FETCH: begin
               mem_req  = 1'b1;
               ir_write = mem_ready;
            end
            EXEC: begin
               alu_src = uses_rs2;
               alu_op  = alu_op_dec;
               if (is_branch) begin
                  pc_write = 1'b1;
                  pc_src   = (iclass == I_BEQ) ? alu_zero : !alu_zero;
               end
            end
            MEM: begin
               mem_req      = 1'b1;
               mem_addr_src = 1'b1;
               mem_we       = (iclass == I_SW);
               alu_src      = uses_rs2;
               alu_op       = alu_op_dec;
               pc_write     = mem_ready && (iclass == I_SW);
            end
            WB: begin
               reg_write  = 1'b1;
               mem_to_reg = (iclass == I_LW);
               pc_write   = 1'b1;
            end
            default: ;
         endcase
         trap       = (state == TRAP);
         trap_cause = cause_q;
         instret    = instret_q;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed literal checks plus a per-cycle schedule-based model.
module tb_multicycle_controller;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = 32'h0;
   logic        mem_ready = 1'b0;
   logic        alu_zero = 1'b0;
   logic        mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src, alu_src;
   logic [3:0]  alu_op;
   logic        reg_write, mem_to_reg, trap;
   logic [1:0]  trap_cause;
   logic [31:0] instret;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   multicycle_controller #(.INSTRET_W(32), .WAIT_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_src(mem_addr_src), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .trap(trap), .trap_cause(trap_cause),
      .instret(instret)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {K_LW, K_SW, K_ADDI, K_ADD, K_SUB, K_BEQ, K_BNE, K_BAD} kind_e;

   bit          m_trap = 0, m_fetch = 1, m_decode = 0;
   logic [1:0]  m_cause = 2'b00;
   logic [31:0] m_ret = 0;
   int          m_wait = 0;
   kind_e       m_kind = K_BAD;
   byte         sched[$];

   function automatic kind_e kind_of(input logic [31:0] w);
      logic [6:0] op, f7;
      logic [2:0] f3;
      op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
      if (op == 7'h03) return K_LW;
      if (op == 7'h23) return K_SW;
      if (op == 7'h13 && f3 == 3'd0) return K_ADDI;
      if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) return K_ADD;
      if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) return K_SUB;
      if (op == 7'h63 && f3 == 3'd0) return K_BEQ;
      if (op == 7'h63 && f3 == 3'd1) return K_BNE;
      return K_BAD;
   endfunction

   always @(negedge clk) begin : model
      logic e_req, e_we, e_as, e_ir, e_pw, e_ps, e_src, e_rw, e_m2r, e_trap;
      logic [3:0]  e_op;
      logic [1:0]  e_cause;
      logic [31:0] e_ret;
      byte ph;
      {e_req, e_we, e_as, e_ir, e_pw, e_ps, e_src, e_rw, e_m2r, e_trap} = '0;
      e_op = 4'd0; e_cause = 2'd0; e_ret = 32'd0;
      ph = "-";
      if (!rst) begin
         e_trap = m_trap; e_cause = m_cause; e_ret = m_ret;
         if (!m_trap && m_fetch) begin
            e_req = 1'b1;
            e_ir  = mem_ready;
         end else if (!m_trap && !m_decode) begin
            ph = sched[0];
            if (ph == "E" || ph == "M") begin
               e_src = (m_kind == K_ADD || m_kind == K_SUB || m_kind == K_BEQ || m_kind == K_BNE);
               e_op  = (m_kind == K_SUB || m_kind == K_BEQ || m_kind == K_BNE) ? 4'd1 : 4'd0;
            end
            if (ph == "E" && (m_kind == K_BEQ || m_kind == K_BNE)) begin
               e_pw = 1'b1;
               e_ps = (m_kind == K_BEQ) ? alu_zero : !alu_zero;
            end
            if (ph == "M") begin
               e_req = 1'b1; e_as = 1'b1;
               e_we  = (m_kind == K_SW);
               e_pw  = mem_ready && (m_kind == K_SW);
            end
            if (ph == "W") begin
               e_rw = 1'b1; e_pw = 1'b1;
               e_m2r = (m_kind == K_LW);
            end
         end
      end
      check("model_ctrl",
            {mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src, alu_src, alu_op,
             reg_write, mem_to_reg, trap, trap_cause},
            {e_req, e_we, e_as, e_ir, e_pw, e_ps, e_src, e_op, e_rw, e_m2r, e_trap, e_cause});
      check("model_instret", instret, e_ret);

      m_ret = m_ret + 32'(e_pw);
      if (rst) begin
         m_trap = 0; m_fetch = 1; m_decode = 0; m_cause = 2'b00; m_ret = 0; m_wait = 0;
         sched.delete();
      end else if (m_trap) begin
      end else if (m_fetch || ph == "M") begin
         if (mem_ready) begin
            m_wait = 0;
            if (m_fetch) begin m_fetch = 0; m_decode = 1; end
            else void'(sched.pop_front());
         end else begin
            m_wait++;
            if (m_wait == LIMIT) begin m_trap = 1; m_cause = 2'b10; end
         end
      end else if (m_decode) begin
         m_decode = 0;
         m_kind = kind_of(instr);
         case (m_kind)
            K_BAD:                 begin m_trap = 1; m_cause = 2'b01; end
            K_LW:                  sched = '{"E", "M", "W"};
            K_SW:                  sched = '{"E", "M"};
            K_ADDI, K_ADD, K_SUB:  sched = '{"E", "W"};
            default:               sched = '{"E"};
         endcase
      end else begin
         void'(sched.pop_front());
      end
      if (!rst && !m_trap && !m_fetch && !m_decode && sched.size() == 0) m_fetch = 1;
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic r, input logic rdy, input logic z, input logic [31:0] w);
      @(posedge clk);
      #1;
      rst = r; mem_ready = rdy; alu_zero = z; instr = w;
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 11))
         0:  w[6:0] = 7'h03;
         1:  w[6:0] = 7'h23;
         2:  begin w[6:0] = 7'h13; w[14:12] = 3'd0; end
         3:  begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h00; end
         4:  begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h20; end
         5:  begin w[6:0] = 7'h63; w[14:12] = 3'd0; end
         6:  begin w[6:0] = 7'h63; w[14:12] = 3'd1; end
         7:  ;
         8:  begin w[6:0] = 7'h13; w[14:12] = 3'($urandom_range(1, 7)); end
         9:  begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h01; end
         10: begin w[6:0] = 7'h63; w[14:12] = 3'($urandom_range(2, 7)); end
         default: w[6:0] = 7'h7F;
      endcase
      return w;
   endfunction

   localparam logic [31:0] ADD_I = 32'h002081B3;
   localparam logic [31:0] LW_I  = 32'h0000A103;
   localparam logic [31:0] BEQ_I = 32'h00208463;
   localparam logic [31:0] BNE_I = 32'h00209463;
   localparam logic [31:0] SW_I  = 32'h0020A023;
   localparam logic [31:0] BAD_I = 32'h0000007F;

   initial begin
      int trap_age;
      logic [31:0] w;

      // reset and add
      step(1, 1, 0, ADD_I);
      check("rst_mem_req", mem_req, 0);
      check("rst_instret", instret, 0);
      check("rst_trap", {trap, trap_cause}, 0);
      step(0, 1, 0, ADD_I); check("add_c0_ir_write", {mem_req, ir_write}, 2'b11);
      step(0, 1, 0, ADD_I); check("add_c1_idle", {mem_req, ir_write, pc_write}, 0);
      step(0, 1, 0, ADD_I); check("add_c2_alu", {alu_src, alu_op, pc_write}, 6'b1_0000_0);
      step(0, 1, 0, ADD_I); check("add_c3_wb", {reg_write, pc_write, pc_src, mem_to_reg}, 4'b1100);
      step(0, 1, 0, ADD_I); check("add_instret", instret, 1);

      // lw with two wait cycles in MEM
      step(1, 1, 0, LW_I);
      step(0, 1, 0, LW_I);
      step(0, 1, 0, LW_I);
      step(0, 1, 0, LW_I); check("lw_c2_alu", {alu_src, alu_op}, 0);
      step(0, 0, 0, LW_I); check("lw_c3_mem", {mem_req, mem_addr_src, mem_we}, 3'b110);
      step(0, 0, 0, LW_I); check("lw_c4_mem", {mem_req, mem_addr_src, pc_write}, 3'b110);
      step(0, 1, 0, LW_I); check("lw_c5_mem", {mem_req, mem_addr_src, reg_write}, 3'b110);
      step(0, 1, 0, LW_I); check("lw_c6_wb", {reg_write, mem_to_reg, pc_write}, 3'b111);
      step(0, 1, 0, LW_I); check("lw_instret", instret, 1);

      // beq taken / not taken (fetch of the next one is the cycle just stepped)
      step(0, 1, 0, BEQ_I);
      step(0, 1, 1, BEQ_I); check("beq_taken", {pc_write, pc_src, alu_src, alu_op}, 7'b11_1_0001);
      step(0, 1, 0, BEQ_I);
      step(0, 1, 0, BEQ_I);
      step(0, 1, 0, BEQ_I); check("beq_not_taken", {pc_write, pc_src}, 2'b10);

      // bne taken
      step(0, 1, 0, BNE_I);
      step(0, 1, 0, BNE_I);
      step(0, 1, 0, BNE_I); check("bne_taken", {pc_write, pc_src}, 2'b11);

      // sw with zero-wait memory
      step(0, 1, 0, SW_I);
      step(0, 1, 0, SW_I);
      step(0, 1, 0, SW_I);
      step(0, 1, 0, SW_I); check("sw_c3", {mem_we, pc_write, reg_write, pc_src}, 4'b1100);
      step(0, 1, 0, SW_I); check("sw_instret", instret, 5);

      // reset mid-MEM of a sw
      step(0, 1, 0, SW_I);
      step(0, 1, 0, SW_I);
      step(0, 0, 0, SW_I); check("swr_mem_wait", {mem_we, pc_write}, 2'b10);
      check("swr_instret_held", instret, 5);
      step(1, 1, 0, SW_I); check("swr_rst_no_write", {pc_write, mem_req, instret}, 0);
      step(0, 1, 0, SW_I); check("swr_after_rst", {mem_req, instret}, {1'b1, 32'd0});

      // illegal opcode
      step(1, 1, 0, BAD_I);
      step(0, 1, 0, BAD_I);
      step(0, 1, 0, BAD_I);
      step(0, 1, 0, BAD_I); check("ill_trap", {trap, trap_cause, mem_req}, 4'b1010);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, BAD_I); check("ill_trap_held", {trap, trap_cause, mem_req, pc_write}, 5'b10100);
      end
      step(1, 1, 0, BAD_I);
      step(0, 0, 0, BAD_I); check("ill_rst_clear", {trap, mem_req, instret}, {2'b01, 32'd0});

      // fetch timeout: this fetch cycle is wait 1, three more waits before trap
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, BAD_I); check("to_waiting", {trap, mem_req}, 2'b01);
      end
      step(0, 0, 0, BAD_I); check("to_trap", {trap, trap_cause, mem_req}, 4'b1100);

      // randomized phase
      trap_age = 0;
      for (int n = 0; n < 4000; n++) begin
         @(posedge clk);
         #1;
         trap_age = m_trap ? trap_age + 1 : 0;
         rst       = ($urandom_range(0, 199) == 0) || (trap_age > 3);
         mem_ready = ($urandom_range(0, 9) < 6);
         alu_zero  = 1'($urandom_range(0, 1));
         if (m_decode) begin
            w = rand_instr();
            instr = w;
         end else if (m_fetch) begin
            instr = $urandom;
         end
      end
      @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
